psa_cmd_loader: RTL and testbench

- Upstream command stage for the pattern search accelerator (PSA).
- Accepts a framed byte stream from the host link (UART RX side): block start address, block length, pattern length and pattern bytes.
- Stores the pattern in a small register file and presents stable search parameters to the search engine.
- Issues a one-cycle start pulse, then holds off new commands until the engine reports done.

---
 rtl/psa_pkg.sv | 21 ++
 rtl/psa_pattern_regfile.sv | 30 +++
 rtl/psa_cmd_loader.sv | 174 +++++++++++++++++
 tb/tb_psa_cmd_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psa_pkg.sv
// Shared constants and loader state type for the pattern search accelerator.
// Imported by the command loader, its pattern register file and the search engine.
package psa_pkg;

  localparam logic [7:0] PSA_SYNC_BYTE = 8'hA5;
  localparam int PSA_MAX_PAT_LEN = 16;
  localparam int PSA_ADDR_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    GET_START,
    GET_BLEN,
    GET_PLEN,
    GET_PAT,
    GET_CSUM,
    LAUNCH,
    WAIT_DONE,
    ERR
  } ld_state_t;

endpackage

// File: rtl/psa_pattern_regfile.sv
// Pattern byte store: DEPTH x 8 registers, sync write, async read, sync reset.
// Ports: CLK100MHZ, reset, we/waddr/wdata write port, raddr/rdata read port.
module psa_pattern_regfile #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/psa_cmd_loader.sv
// PSA command loader: parses SYNC/start/len/plen/pattern frames from the host
// link, holds stable search parameters, pulses start and waits for done.
// Ports: CLK100MHZ, reset (sync, high); rx_valid/rx_data/rx_ready byte input;
// pat_rd_idx/pat_rd_data pattern read; blk_start, blk_len, pat_len, start,
// search_done, busy, err.
// Option: define PSA_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module psa_cmd_loader
  import psa_pkg::*;
#(
  parameter int MAX_PAT_LEN = PSA_MAX_PAT_LEN,
  parameter int ADDR_W = PSA_ADDR_W
) (
  input  logic                           CLK100MHZ,
  input  logic                           reset,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           rx_ready,
  input  logic [$clog2(MAX_PAT_LEN)-1:0] pat_rd_idx,
  output logic [7:0]                     pat_rd_data,
  output logic [ADDR_W-1:0]              blk_start,
  output logic [ADDR_W-1:0]              blk_len,
  output logic [$clog2(MAX_PAT_LEN):0]   pat_len,
  output logic                           start,
  input  logic                           search_done,
  output logic                           busy,
  output logic                           err
);

  localparam int IW = $clog2(MAX_PAT_LEN);
  localparam int LW = IW + 1;
  localparam logic [ADDR_W:0] SPAN = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t state, state_n;

  logic [ADDR_W-1:0] bs_q;
  logic [ADDR_W-1:0] bl_q;
  logic [LW-1:0]     pl_q;
  logic [IW-1:0]     idx_q;

  logic            xfer;
  logic            plen_bad;
  logic            last_pat;
  logic            wr_en;
  logic [ADDR_W:0] end_addr;

`ifdef PSA_CMD_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  assign rx_ready = (state != LAUNCH) && (state != WAIT_DONE);
  assign xfer = rx_valid && rx_ready;

  // One extra bit so a block ending exactly at the top of BRAM is legal.
  assign end_addr = {1'b0, bs_q} + {1'b0, bl_q};

  assign plen_bad = (rx_data == 8'h00)
                 || (int'(rx_data) > MAX_PAT_LEN)
                 || (int'(rx_data) > int'(bl_q))
                 || (end_addr > SPAN);

  assign last_pat = ({1'b0, idx_q} == (pl_q - LW'(1)));
  assign wr_en = xfer && (state == GET_PAT);

  always_comb begin
    state_n = state;
    start = 1'b0;
    err = 1'b0;
    busy = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer && rx_data == PSA_SYNC_BYTE) state_n = GET_START;
      end
      GET_START: begin
        busy = 1'b1;
        if (xfer) state_n = GET_BLEN;
      end
      GET_BLEN: begin
        busy = 1'b1;
        if (xfer) state_n = GET_PLEN;
      end
      GET_PLEN: begin
        busy = 1'b1;
        if (xfer) state_n = plen_bad ? ERR : GET_PAT;
      end
      GET_PAT: begin
        busy = 1'b1;
`ifdef PSA_CMD_CHECKSUM_EN
        if (xfer && last_pat) state_n = GET_CSUM;
`else
        if (xfer && last_pat) state_n = LAUNCH;
`endif
      end
      GET_CSUM: begin
`ifdef PSA_CMD_CHECKSUM_EN
        busy = 1'b1;
        if (xfer) state_n = (rx_data == csum_q) ? LAUNCH : ERR;
`else
        state_n = IDLE;
`endif
      end
      LAUNCH: begin
        busy = 1'b1;
        start = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = !search_done;
        if (search_done) state_n = IDLE;
      end
      ERR: begin
        err = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= IDLE;
      bs_q <= '0;
      bl_q <= '0;
      pl_q <= '0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        unique case (state)
          GET_START: bs_q <= ADDR_W'(rx_data);
          GET_BLEN: bl_q <= ADDR_W'(rx_data);
          GET_PLEN: begin
            if (!plen_bad) pl_q <= LW'(rx_data);
            idx_q <= '0;
          end
          GET_PAT: idx_q <= idx_q + IW'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef PSA_CMD_CHECKSUM_EN
  // Running XOR of every byte after SYNC through the last pattern byte.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else if (xfer) begin
      unique case (state)
        IDLE: csum_q <= 8'h00;
        GET_START, GET_BLEN, GET_PLEN, GET_PAT:
          csum_q <= csum_q ^ rx_data;
        default: ;
      endcase
    end
  end
`endif

  assign blk_start = bs_q;
  assign blk_len = bl_q;
  assign pat_len = pl_q;

  psa_pattern_regfile #(
    .DEPTH(MAX_PAT_LEN)
  ) u_regfile (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .we(wr_en),
    .waddr(idx_q),
    .wdata(rx_data),
    .raddr(pat_rd_idx),
    .rdata(pat_rd_data)
  );

endmodule

// File: tb/tb_psa_cmd_loader.sv
// Self-checking bench for psa_cmd_loader: frame table, corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_psa_cmd_loader;

  localparam int MAXP = 16;
  localparam int AWB = 8;

  logic       CLK100MHZ = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [3:0] pat_rd_idx;
  logic [7:0] pat_rd_data;
  logic [7:0] blk_start;
  logic [7:0] blk_len;
  logic [4:0] pat_len;
  logic       start;
  logic       search_done;
  logic       busy;
  logic       err;

  psa_cmd_loader #(
    .MAX_PAT_LEN(MAXP),
    .ADDR_W(AWB)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .pat_rd_idx(pat_rd_idx),
    .pat_rd_data(pat_rd_data),
    .blk_start(blk_start),
    .blk_len(blk_len),
    .pat_len(pat_len),
    .start(start),
    .search_done(search_done),
    .busy(busy),
    .err(err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic [159:0] f;
    int           n;
    bit           ok;
    logic [7:0]   bs;
    logic [7:0]   bl;
    int           pl;
  } vec_t;

  typedef struct {
    bit         ok;
    logic [7:0] bs;
    logic [7:0] bl;
    int         pl;
    logic [7:0] pat [16];
  } exp_t;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  always @(negedge CLK100MHZ) begin
    if (start) start_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge CLK100MHZ);
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge CLK100MHZ);
      n++;
    end
    chk("rx_ready_wait", 32'(rx_ready), 1);
    @(posedge CLK100MHZ);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] csum_of(input exp_t e);
    logic [7:0] c;
    c = e.bs ^ e.bl ^ 8'(e.pl);
    for (int j = 0; j < e.pl; j++) c ^= e.pat[j];
    return c;
  endfunction

  // Frame-level reference: skip garbage, apply the header rules, then
  // read the pattern (and checksum, when enabled). used = bytes consumed.
  function automatic void model(input logic [7:0] q[$], output exp_t e,
                                output int used);
    int i;
    i = 0;
    e.ok = 0;
    foreach (e.pat[j]) e.pat[j] = 8'h00;
    while (i < q.size() && q[i] != 8'hA5) i++;
    i++;
    e.bs = q[i];
    e.bl = q[i+1];
    e.pl = int'(q[i+2]);
    i += 3;
    used = i;
    if (e.pl < 1 || e.pl > MAXP || e.pl > int'(e.bl)
        || int'(e.bs) + int'(e.bl) > (1 << AWB)) return;
    for (int j = 0; j < e.pl; j++) begin
      e.pat[j] = q[i];
      i++;
    end
    used = i;
    e.ok = 1;
`ifdef PSA_CMD_CHECKSUM_EN
    e.ok = (q[i] == csum_of(e));
    used = i + 1;
`endif
  endfunction

  task automatic run_frame(input logic [7:0] q[$], input exp_t e);
    int s0;
    int e0;
    s0 = start_cnt;
    e0 = err_cnt;
    foreach (q[k]) send(q[k]);
    @(negedge CLK100MHZ);
    if (e.ok) begin
      chk("start", 32'(start), 1);
      chk("launch_rdy", 32'(rx_ready), 0);
      chk("launch_busy", 32'(busy), 1);
      chk("blk_start", 32'(blk_start), 32'(e.bs));
      chk("blk_len", 32'(blk_len), 32'(e.bl));
      chk("pat_len", 32'(pat_len), 32'(e.pl));
      for (int j = 0; j < e.pl; j++) begin
        pat_rd_idx = 4'(j);
        #1;
        chk("pat_byte", 32'(pat_rd_data), 32'(e.pat[j]));
      end
      @(negedge CLK100MHZ);
      chk("wait_busy", 32'(busy), 1);
      chk("wait_rdy", 32'(rx_ready), 0);
      chk("start_width", 32'(start), 0);
      search_done = 1'b1;
      @(negedge CLK100MHZ);
      search_done = 1'b0;
      chk("done_busy", 32'(busy), 0);
      chk("done_rdy", 32'(rx_ready), 1);
      chk("n_start", 32'(start_cnt - s0), 1);
      chk("n_err", 32'(err_cnt - e0), 0);
    end else begin
      chk("err", 32'(err), 1);
      chk("err_nostart", 32'(start), 0);
      chk("err_busy", 32'(busy), 0);
      @(negedge CLK100MHZ);
      chk("err_width", 32'(err), 0);
      chk("err_rdy", 32'(rx_ready), 1);
      chk("n_start", 32'(start_cnt - s0), 0);
      chk("n_err", 32'(err_cnt - e0), 1);
    end
  endtask

  task automatic vec_to(input vec_t v, output logic [7:0] q[$],
                        output exp_t e);
    q.delete();
    for (int k = 0; k < v.n; k++) q.push_back(v.f[8*(v.n-1-k) +: 8]);
    e.ok = v.ok;
    e.bs = v.bs;
    e.bl = v.bl;
    e.pl = v.pl;
    foreach (e.pat[j]) e.pat[j] = 8'h00;
    if (v.ok) begin
      for (int j = 0; j < v.pl; j++) e.pat[j] = q[v.n - v.pl + j];
`ifdef PSA_CMD_CHECKSUM_EN
      q.push_back(csum_of(e));
`endif
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK100MHZ);
    reset = 1'b1;
    @(negedge CLK100MHZ);
    reset = 1'b0;
  endtask

  task automatic idle_checks(input string nm, input int s0, input int e0);
    chk({nm, "_rdy"}, 32'(rx_ready), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_start"}, 32'(start), 0);
    chk({nm, "_err"}, 32'(err), 0);
    search_done = 1'b1;
    @(negedge CLK100MHZ);
    search_done = 1'b0;
    @(negedge CLK100MHZ);
    chk({nm, "_stray_rdy"}, 32'(rx_ready), 1);
    chk({nm, "_stray_busy"}, 32'(busy), 0);
    chk({nm, "_n_start"}, 32'(start_cnt - s0), 0);
    chk({nm, "_n_err"}, 32'(err_cnt - e0), 0);
  endtask

  vec_t tbl [11];

  initial begin
    logic [7:0] q[$];
    exp_t e;
    int s0;
    int e0;
    int used;

    tbl[0] = '{160'hA5102003414243, 7, 1, 8'h10, 8'h20, 3};
    tbl[1] = '{160'h00FF13A5102003414243, 10, 1, 8'h10, 8'h20, 3};
    tbl[2] = '{160'hA5F02002, 4, 0, 8'hF0, 8'h20, 2};
    tbl[3] = '{160'hA5100203, 4, 0, 8'h10, 8'h02, 3};
    tbl[4] = '{160'hA5102000, 4, 0, 8'h10, 8'h20, 0};
    tbl[5] = '{160'hA5102011, 4, 0, 8'h10, 8'h20, 17};
    tbl[6] = '{160'hA5F01002C0DE, 6, 1, 8'hF0, 8'h10, 2};
    tbl[7] = '{160'hA510040401020304, 8, 1, 8'h10, 8'h04, 4};
    tbl[8] = '{160'hA500FF10_00112233445566778899AABBCCDDEEFF,
               20, 1, 8'h00, 8'hFF, 16};
    tbl[9] = '{160'hA5FF010177, 5, 1, 8'hFF, 8'h01, 1};
    tbl[10] = '{160'hA5FF0201, 4, 0, 8'hFF, 8'h02, 1};

    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    search_done = 1'b0;
    pat_rd_idx = 4'd0;
    repeat (3) @(negedge CLK100MHZ);
    reset = 1'b0;
    @(negedge CLK100MHZ);
    chk("rst_rdy", 32'(rx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_bs", 32'(blk_start), 0);
    chk("rst_bl", 32'(blk_len), 0);
    chk("rst_pl", 32'(pat_len), 0);
    chk("rst_pat", 32'(pat_rd_data), 0);

    foreach (tbl[i]) begin
      vec_to(tbl[i], q, e);
      run_frame(q, e);
    end

    // Reset in the middle of the pattern bytes.
    s0 = start_cnt;
    e0 = err_cnt;
    q = '{8'hA5, 8'h10, 8'h20, 8'h03, 8'h41};
    foreach (q[k]) send(q[k]);
    pulse_reset();
    pat_rd_idx = 4'd0;
    #1;
    chk("rstpat_pat0", 32'(pat_rd_data), 0);
    chk("rstpat_bs", 32'(blk_start), 0);
    idle_checks("rstpat", s0, e0);

    // Reset while waiting for the engine.
    vec_to(tbl[0], q, e);
    foreach (q[k]) send(q[k]);
    @(negedge CLK100MHZ);
    chk("rstwait_start", 32'(start), 1);
    @(negedge CLK100MHZ);
    s0 = start_cnt;
    e0 = err_cnt;
    pulse_reset();
    idle_checks("rstwait", s0, e0);

    // search_done held high across LAUNCH.
    s0 = start_cnt;
    search_done = 1'b1;
    vec_to(tbl[0], q, e);
    foreach (q[k]) send(q[k]);
    @(negedge CLK100MHZ);
    chk("hold_start", 32'(start), 1);
    @(negedge CLK100MHZ);
    chk("hold_wait_rdy", 32'(rx_ready), 0);
    @(negedge CLK100MHZ);
    chk("hold_idle_rdy", 32'(rx_ready), 1);
    chk("hold_idle_busy", 32'(busy), 0);
    chk("hold_n_start", 32'(start_cnt - s0), 1);
    search_done = 1'b0;
    vec_to(tbl[7], q, e);
    run_frame(q, e);

`ifdef PSA_CMD_CHECKSUM_EN
    // Corrupted checksum must be rejected after the checksum byte.
    vec_to(tbl[9], q, e);
    q[q.size()-1] = q[q.size()-1] ^ 8'h01;
    e.ok = 0;
    run_frame(q, e);
`endif

    for (int r = 0; r < 40; r++) begin
      logic [7:0] b;
      logic [7:0] bs;
      logic [7:0] bl;
      int pl;
      q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        q.push_back(b);
      end
      bs = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        bl = 8'($urandom_range(0, 255));
        pl = $urandom_range(0, 20);
      end else begin
        bl = (bs == 8'hFF) ? 8'd1 : 8'($urandom_range(1, 255 - int'(bs)));
        pl = $urandom_range(1, (int'(bl) < MAXP) ? int'(bl) : MAXP);
      end
      q.push_back(8'hA5);
      q.push_back(bs);
      q.push_back(bl);
      q.push_back(8'(pl));
      b = bs ^ bl ^ 8'(pl);
      for (int j = 0; j < pl; j++) begin
        q.push_back(8'($urandom_range(0, 255)));
        b ^= q[q.size()-1];
      end
      if ($urandom_range(0, 3) == 0) b ^= 8'h5A;
      q.push_back(b);
      model(q, e, used);
      while (q.size() > used) void'(q.pop_back());
      run_frame(q, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
